// File: rtl/regmodel0_mutex_pkg.sv
// rtl/regmodel0_mutex_pkg.sv - shared types and constants for the regmodel0 mutex bank
// Purpose: field widths, per-mutex state record and the decoded access operation.
// Ports: none (package).
package regmodel0_mutex_pkg;

    localparam int REQINFO_W = 6;
    localparam int SWID_W    = 31;

    typedef struct packed {
        logic                 locked;
        logic [REQINFO_W-1:0] owner;
        logic [SWID_W-1:0]    swid;
        logic                 contended;
    } mutex_entry_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ACQ  = 2'd1,
        OP_REL  = 2'd2
    } mtx_op_e;

endpackage

// File: rtl/regmodel0_mutex_entry.sv
// rtl/regmodel0_mutex_entry.sv - one hardware mutex: try-lock, owner-only release, optional hold timeout
// Purpose: holds one mutex_entry_t and applies the decoded operation for this entry.
// Optional feature macro: REGMODEL0_MUTEX_TIMEOUT_EN (hold counter, forced release, to_o).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   op_i             decoded operation addressed to this entry
//   reqinfo_i        requester ID of the access
//   swid_din_i       software ID of the access
//   swid_w_i         swid field write strobe
//   rel_o            registered pulse: contended (or timed-out) mutex freed
//   err_o            registered pulse: rejected release
//   to_o             registered pulse: forced release by timeout (feature only)
//   locked_o         current lock state
//   rd_locked_o      post-update lock state, for same-cycle readback
//   rd_swid_o        post-update swid, for same-cycle readback
module regmodel0_mutex_entry
    import regmodel0_mutex_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  mtx_op_e              op_i,
    input  logic [REQINFO_W-1:0] reqinfo_i,
    input  logic [SWID_W-1:0]    swid_din_i,
    input  logic                 swid_w_i,
    output logic                 rel_o,
    output logic                 err_o,
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
    output logic                 to_o,
`endif
    output logic                 locked_o,
    output logic                 rd_locked_o,
    output logic [SWID_W-1:0]    rd_swid_o
);

    mutex_entry_t      st_q, st_d;
    logic              rel_q, rel_d;
    logic              err_q, err_d;
    logic [SWID_W-1:0] acq_swid;

`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             timeout_hit;

    assign timeout_hit = st_q.locked && (cnt_q == CNT_LAST);
`endif

    // swid is only taken from the bus when its strobe accompanies the lock op
    assign acq_swid = swid_w_i ? swid_din_i : '0;

    always_comb begin
        st_d  = st_q;
        rel_d = 1'b0;
        err_d = 1'b0;
        case (op_i)
            OP_ACQ: begin
                if (!st_q.locked) begin
                    st_d.locked    = 1'b1;
                    st_d.owner     = reqinfo_i;
                    st_d.swid      = acq_swid;
                    st_d.contended = 1'b0;
                end else if (!((st_q.owner == reqinfo_i) && (st_q.swid == acq_swid))) begin
                    // a different requester lost the race; remember it so the
                    // eventual release wakes the waiters
                    st_d.contended = 1'b1;
                end
            end
            OP_REL: begin
                if (st_q.locked) begin
                    if ((st_q.owner == reqinfo_i) && (st_q.swid == swid_din_i)) begin
                        st_d  = '0;
                        rel_d = st_q.contended;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
        // a successful owner release this cycle already cleared locked, so
        // the forced release only fires when the mutex would stay held
        to_d = 1'b0;
        if (timeout_hit && st_d.locked) begin
            st_d  = '0;
            rel_d = 1'b1;
            to_d  = 1'b1;
        end
        // counter restarts on a fresh acquire and idles at zero while free
        if (!st_q.locked || !st_d.locked) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= '0;
            rel_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            rel_q <= rel_d;
            err_q <= err_d;
        end
    end

`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign to_o = to_q;
`endif

    assign rel_o       = rel_q;
    assign err_o       = err_q;
    assign locked_o    = st_q.locked;
    assign rd_locked_o = st_d.locked;
    assign rd_swid_o   = st_d.swid;

endmodule

// File: rtl/regmodel0_mutex_ctrl.sv
// rtl/regmodel0_mutex_ctrl.sv - regmodel0 mutex register slave: bank of NUM_MTX hardware mutexes
// Purpose: decodes swid/lock register writes into per-mutex acquire/release,
//          muxes swid/lock readback and collects release/error events.
// Optional feature macro: REGMODEL0_MUTEX_TIMEOUT_EN (forced release after TIMEOUT_CYC, to_evt port).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   mtx_sel      mutex index of the current access
//   reqinfo      requester ID of the current access
//   swid_din     swid write data, swid_w its strobe
//   swid_r       register read strobe
//   lock_din     lock write value, lock_w its strobe (decides the operation)
//   swid_qout    readback swid, lock_qout readback lock (held until next swid_r)
//   rel_evt      per-mutex release pulse
//   err_evt      rejected release pulse
//   to_evt       forced-release pulse (feature only)
//   lock_vec     live lock state of all mutexes
module regmodel0_mutex_ctrl
    import regmodel0_mutex_pkg::*;
#(
    parameter int NUM_MTX     = 8,
    parameter int SEL_W       = (NUM_MTX > 1) ? $clog2(NUM_MTX) : 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_W-1:0]     mtx_sel,
    input  logic [REQINFO_W-1:0] reqinfo,
    input  logic [SWID_W-1:0]    swid_din,
    input  logic                 swid_w,
    input  logic                 swid_r,
    input  logic                 lock_din,
    input  logic                 lock_w,
    output logic [SWID_W-1:0]    swid_qout,
    output logic                 lock_qout,
    output logic [NUM_MTX-1:0]   rel_evt,
    output logic                 err_evt,
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
    output logic                 to_evt,
`endif
    output logic [NUM_MTX-1:0]   lock_vec
);

    if ((NUM_MTX < 1) || (NUM_MTX > 32) || (TIMEOUT_CYC < 2)) begin : g_param_check
        $error("regmodel0_mutex_ctrl: parameter out of range");
    end

    mtx_op_e           op       [NUM_MTX];
    logic              rd_locked[NUM_MTX];
    logic [SWID_W-1:0] rd_swid  [NUM_MTX];
    logic [NUM_MTX-1:0] err_vec;
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
    logic [NUM_MTX-1:0] to_vec;
`endif

    logic [SWID_W-1:0] swid_qout_q, swid_qout_d;
    logic              lock_qout_q, lock_qout_d;

    // an out-of-range select matches no entry, so writes fall on the floor
    always_comb begin
        for (int i = 0; i < NUM_MTX; i++) begin
            op[i] = OP_NONE;
            if (lock_w && (mtx_sel == SEL_W'(i))) begin
                op[i] = lock_din ? OP_ACQ : OP_REL;
            end
        end
    end

    for (genvar g = 0; g < NUM_MTX; g++) begin : g_entry
        regmodel0_mutex_entry #(
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .op_i        (op[g]),
            .reqinfo_i   (reqinfo),
            .swid_din_i  (swid_din),
            .swid_w_i    (swid_w),
            .rel_o       (rel_evt[g]),
            .err_o       (err_vec[g]),
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
            .to_o        (to_vec[g]),
`endif
            .locked_o    (lock_vec[g]),
            .rd_locked_o (rd_locked[g]),
            .rd_swid_o   (rd_swid[g])
        );
    end

    // readback samples post-update state so write+read in one cycle reports
    // whether the write took effect
    always_comb begin
        swid_qout_d = swid_qout_q;
        lock_qout_d = lock_qout_q;
        if (swid_r) begin
            swid_qout_d = '0;
            lock_qout_d = 1'b0;
            for (int i = 0; i < NUM_MTX; i++) begin
                if (mtx_sel == SEL_W'(i)) begin
                    swid_qout_d = rd_swid[i];
                    lock_qout_d = rd_locked[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swid_qout_q <= '0;
            lock_qout_q <= 1'b0;
        end else begin
            swid_qout_q <= swid_qout_d;
            lock_qout_q <= lock_qout_d;
        end
    end

    assign swid_qout = swid_qout_q;
    assign lock_qout = lock_qout_q;
    assign err_evt   = |err_vec;
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
    assign to_evt    = |to_vec;
`endif

endmodule

// File: tb/tb_regmodel0_mutex_ctrl.sv
// tb/tb_regmodel0_mutex_ctrl.sv - directed self-checking bench for regmodel0_mutex_ctrl
module tb_regmodel0_mutex_ctrl;

    localparam int NUM_MTX = 6;
    localparam int SEL_W   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SEL_W-1:0]  mtx_sel = '0;
    logic [5:0]        reqinfo = '0;
    logic [30:0]       swid_din = '0;
    logic              swid_w = 1'b0;
    logic              swid_r = 1'b0;
    logic              lock_din = 1'b0;
    logic              lock_w = 1'b0;
    logic [30:0]       swid_qout;
    logic              lock_qout;
    logic [NUM_MTX-1:0] rel_evt;
    logic              err_evt;
    logic [NUM_MTX-1:0] lock_vec;
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
    logic              to_evt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regmodel0_mutex_ctrl #(
        .NUM_MTX     (NUM_MTX),
        .SEL_W       (SEL_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mtx_sel   (mtx_sel),
        .reqinfo   (reqinfo),
        .swid_din  (swid_din),
        .swid_w    (swid_w),
        .swid_r    (swid_r),
        .lock_din  (lock_din),
        .lock_w    (lock_w),
        .swid_qout (swid_qout),
        .lock_qout (lock_qout),
        .rel_evt   (rel_evt),
        .err_evt   (err_evt),
`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
        .to_evt    (to_evt),
`endif
        .lock_vec  (lock_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one access cycle; outputs are sampled 1 time unit after the edge
    task automatic access(input logic [2:0] sel, input logic [5:0] req, input logic [30:0] sw,
                          input logic sww, input logic rd, input logic ldin, input logic lw);
        mtx_sel  = sel;
        reqinfo  = req;
        swid_din = sw;
        swid_w   = sww;
        swid_r   = rd;
        lock_din = ldin;
        lock_w   = lw;
        @(posedge clk);
        #1;
        mtx_sel  = '0;
        reqinfo  = '0;
        swid_din = '0;
        swid_w   = 1'b0;
        swid_r   = 1'b0;
        lock_din = 1'b0;
        lock_w   = 1'b0;
    endtask

    task automatic idle();
        access(3'd0, 6'd0, 31'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_lock_vec", 32'(lock_vec), 32'h0);
        chk("reset_swid_qout", 32'(swid_qout), 32'h0);
        chk("reset_lock_qout", 32'(lock_qout), 32'h0);
        chk("reset_rel_evt", 32'(rel_evt), 32'h0);
        chk("reset_err_evt", 32'(err_evt), 32'h0);

        // acquire mutex 2 by requester 5, then read it back
        access(3'd2, 6'd5, 31'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("acq2_lock_vec", 32'(lock_vec), 32'h04);
        access(3'd2, 6'd0, 31'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rd2_lock_qout", 32'(lock_qout), 32'h1);
        chk("rd2_swid_qout", 32'(swid_qout), 32'h1234);

        // requester 7 contends; no state change, readback holds
        access(3'd2, 6'd7, 31'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("contend_lock_vec", 32'(lock_vec), 32'h04);
        chk("contend_err", 32'(err_evt), 32'h0);
        chk("readback_hold", 32'(swid_qout), 32'h1234);
        access(3'd2, 6'd0, 31'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("contend_swid_kept", 32'(swid_qout), 32'h1234);

        // rejected releases
        access(3'd2, 6'd7, 31'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rel_wrong_owner_err", 32'(err_evt), 32'h1);
        chk("rel_wrong_owner_lock", 32'(lock_vec), 32'h04);
        idle();
        chk("err_one_pulse", 32'(err_evt), 32'h0);
        access(3'd2, 6'd5, 31'h9999, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rel_wrong_swid_err", 32'(err_evt), 32'h1);
        chk("rel_wrong_swid_lock", 32'(lock_vec), 32'h04);

        // owner release of contended mutex wakes waiters
        access(3'd2, 6'd5, 31'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rel2_rel_evt", 32'(rel_evt), 32'h04);
        chk("rel2_lock_vec", 32'(lock_vec), 32'h0);
        chk("rel2_err", 32'(err_evt), 32'h0);
        idle();
        chk("rel_one_pulse", 32'(rel_evt), 32'h0);

        // release of unlocked mutex: silent
        access(3'd2, 6'd5, 31'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rel_unlocked_err", 32'(err_evt), 32'h0);
        chk("rel_unlocked_rel", 32'(rel_evt), 32'h0);

        // write+read same cycle on mutex 0
        access(3'd0, 6'd1, 31'hABC, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("wr_rd0_lock_qout", 32'(lock_qout), 32'h1);
        chk("wr_rd0_swid_qout", 32'(swid_qout), 32'hABC);
        chk("wr_rd0_lock_vec", 32'(lock_vec), 32'h01);

        // self re-acquire does not mark contention
        access(3'd0, 6'd1, 31'hABC, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("self_reacq_lock_vec", 32'(lock_vec), 32'h01);
        access(3'd0, 6'd1, 31'hABC, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("self_rel_no_evt", 32'(rel_evt), 32'h0);
        chk("self_rel_lock_vec", 32'(lock_vec), 32'h0);

        // out-of-range select: write ignored, readback zero
        access(3'd6, 6'd1, 31'h55, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("oor_swid_qout", 32'(swid_qout), 32'h0);
        chk("oor_lock_qout", 32'(lock_qout), 32'h0);
        chk("oor_lock_vec", 32'(lock_vec), 32'h0);

        // swid_w without lock_w does nothing
        access(3'd1, 6'd1, 31'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("swid_only_lock_qout", 32'(lock_qout), 32'h0);
        chk("swid_only_swid_qout", 32'(swid_qout), 32'h0);

        // reset while mutexes 0 and 3 are held, 3 contended
        access(3'd0, 6'd1, 31'h1, 1'b1, 1'b0, 1'b1, 1'b1);
        access(3'd3, 6'd2, 31'h3, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("hold03_lock_vec", 32'(lock_vec), 32'h09);
        access(3'd3, 6'd4, 31'h8, 1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_lock_vec", 32'(lock_vec), 32'h0);
        chk("midreset_rel_evt", 32'(rel_evt), 32'h0);
        idle();
        chk("postreset_rel_evt", 32'(rel_evt), 32'h0);
        access(3'd3, 6'd2, 31'h3, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("postreset_rel3_rel", 32'(rel_evt), 32'h0);
        chk("postreset_rel3_err", 32'(err_evt), 32'h0);
        chk("postreset_rd3_lock", 32'(lock_qout), 32'h0);

`ifdef REGMODEL0_MUTEX_TIMEOUT_EN
        begin
            int n;
            access(3'd4, 6'd1, 31'h1, 1'b1, 1'b0, 1'b1, 1'b1);
            n = 0;
            while (n < 40) begin
                @(posedge clk);
                #1;
                n++;
                if (to_evt) break;
            end
            chk("timeout_cycles", 32'(n), 32'd16);
            chk("timeout_rel_evt", 32'(rel_evt), 32'h10);
            chk("timeout_lock_vec", 32'(lock_vec), 32'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
